// File: rtl/ogege_pixel_pkg.sv
// Shared pixel-pipeline definitions: default geometry, channel indices and the
// alpha-to-weight mapping used by the blender.
package ogege_pixel_pkg;

    localparam int DEFAULT_NCH = 3;
    localparam int DEFAULT_CW  = 4;
    localparam int DEFAULT_AW  = 3;

    localparam int CH_R = 0;
    localparam int CH_G = 1;
    localparam int CH_B = 2;

    // Full-scale alpha maps to 2**aw so that an opaque pixel reproduces fg exactly.
    function automatic int unsigned calc_we(input int unsigned alpha, input int unsigned aw);
        int unsigned amax;
        amax = (32'd1 << aw) - 32'd1;
        return (alpha == amax) ? amax + 32'd1 : alpha;
    endfunction

endpackage

// File: rtl/blend_lane.sv
// One colour channel of the blender: S2 weighted products, S3 sum/shift/output.
// BLEND_ROUND_EN selects round-half-up instead of truncation in S3.
module blend_lane
    import ogege_pixel_pkg::*;
#(
    parameter int CW = DEFAULT_CW,
    parameter int AW = DEFAULT_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    input  logic [CW-1:0] fg_i,
    input  logic [CW-1:0] bg_i,
    input  logic [AW:0]   we_i,
    output logic [CW-1:0] color_o
);

    localparam int PW = CW + AW;
    localparam logic [PW-1:0] FULL_W = PW'(1) << AW;
`ifdef BLEND_ROUND_EN
    localparam logic [PW-1:0] HALF_LSB = PW'(1) << (AW - 1);
`endif

    logic [PW-1:0] prod_fg_q, prod_fg_d;
    logic [PW-1:0] prod_bg_q, prod_bg_d;
    logic [CW-1:0] color_q, color_d;
    logic [PW-1:0] sum;

    always_comb begin
        // NOTE: every _d starts from its _q so a held stage is explicit and no latch is inferred.
        prod_fg_d = prod_fg_q;
        prod_bg_d = prod_bg_q;
        color_d   = color_q;
`ifdef BLEND_ROUND_EN
        sum = prod_fg_q + prod_bg_q + HALF_LSB;
`else
        sum = prod_fg_q + prod_bg_q;
`endif
        if (en_i) begin
            // Products never exceed (2**CW-1)*2**AW, so PW bits hold them exactly.
            prod_fg_d = PW'(fg_i) * PW'(we_i);
            prod_bg_d = PW'(bg_i) * (FULL_W - PW'(we_i));
            color_d   = CW'(sum >> AW);
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state registers use non-blocking assignments so all stages update from pre-edge values.
        if (rst_i) begin
            prod_fg_q <= '0;
            prod_bg_q <= '0;
            color_q   <= '0;
        end else begin
            prod_fg_q <= prod_fg_d;
            prod_bg_q <= prod_bg_d;
            color_q   <= color_d;
        end
    end

    assign color_o = color_q;

endmodule

// File: rtl/alpha_blend_pipe.sv
// Three-stage valid/ready alpha blender with sideband pass-through; one global
// advance stalls every stage together. Optional BLEND_ROUND_EN enables rounding.
module alpha_blend_pipe
    import ogege_pixel_pkg::*;
#(
    parameter int NCH = DEFAULT_NCH,
    parameter int CW  = DEFAULT_CW,
    parameter int AW  = DEFAULT_AW,
    parameter int SBW = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [NCH*CW-1:0] fg_i,
    input  logic [NCH*CW-1:0] bg_i,
    input  logic [AW-1:0]     alpha_i,
    input  logic [SBW-1:0]    sb_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [NCH*CW-1:0] color_o,
    output logic [SBW-1:0]    sb_o
);

    localparam int DW  = NCH * CW;
    localparam int WEW = AW + 1;

    logic           adv;
    logic           v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
    logic [DW-1:0]  fg1_q, fg1_d, bg1_q, bg1_d;
    logic [AW:0]    we1_q, we1_d;
    logic [SBW-1:0] sb1_q, sb1_d, sb2_q, sb2_d, sb3_q, sb3_d;

    // The output stage frees up whenever it is empty or being drained.
    assign adv = out_ready_i | ~v3_q;

    always_comb begin
        v1_d  = v1_q;
        v2_d  = v2_q;
        v3_d  = v3_q;
        fg1_d = fg1_q;
        bg1_d = bg1_q;
        we1_d = we1_q;
        sb1_d = sb1_q;
        sb2_d = sb2_q;
        sb3_d = sb3_q;
        if (adv) begin
            v1_d  = in_valid_i;
            v2_d  = v1_q;
            v3_d  = v2_q;
            fg1_d = fg_i;
            bg1_d = bg_i;
            we1_d = WEW'(calc_we(32'(alpha_i), AW));
            sb1_d = sb_i;
            sb2_d = sb1_q;
            sb3_d = sb2_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            fg1_q <= '0;
            bg1_q <= '0;
            we1_q <= '0;
            sb1_q <= '0;
            sb2_q <= '0;
            sb3_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            fg1_q <= fg1_d;
            bg1_q <= bg1_d;
            we1_q <= we1_d;
            sb1_q <= sb1_d;
            sb2_q <= sb2_d;
            sb3_q <= sb3_d;
        end
    end

    for (genvar ch = 0; ch < NCH; ch++) begin : g_lane
        blend_lane #(
            .CW(CW),
            .AW(AW)
        ) u_lane (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .en_i    (adv),
            .fg_i    (fg1_q[ch*CW +: CW]),
            .bg_i    (bg1_q[ch*CW +: CW]),
            .we_i    (we1_q),
            .color_o (color_o[ch*CW +: CW])
        );
    end

    assign in_ready_o  = adv;
    assign out_valid_o = v3_q;
    assign sb_o        = sb3_q;

endmodule

// File: tb/tb_alpha_blend_pipe.sv
// Randomised and directed checks of alpha_blend_pipe against an arithmetic
// reference model and an in-order expectation queue.
module tb_alpha_blend_pipe;
    import ogege_pixel_pkg::*;

    localparam int NCH = 3;
    localparam int CW  = 4;
    localparam int AW  = 3;
    localparam int SBW = 3;
    localparam int DW  = NCH * CW;

`ifdef BLEND_ROUND_EN
    localparam logic [DW-1:0] EXP_FG15_A3 = 12'h666;
`else
    localparam logic [DW-1:0] EXP_FG15_A3 = 12'h555;
`endif

    typedef struct {
        logic [DW-1:0]  color;
        logic [SBW-1:0] sb;
        int             cyc;
    } exp_t;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b1;
    logic           in_valid_i = 1'b0;
    logic           in_ready_o;
    logic [DW-1:0]  fg_i = '0;
    logic [DW-1:0]  bg_i = '0;
    logic [AW-1:0]  alpha_i = '0;
    logic [SBW-1:0] sb_i = '0;
    logic           out_valid_o;
    logic           out_ready_i = 1'b1;
    logic [DW-1:0]  color_o;
    logic [SBW-1:0] sb_o;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cycle    = 0;
    int   n_acc    = 0;
    int   n_emit   = 0;
    bit   lat_chk  = 1'b0;
    bit   stall_prev = 1'b0;
    logic [DW-1:0]  prev_color, last_color;
    logic [SBW-1:0] prev_sb;
    exp_t exp_q[$];

    alpha_blend_pipe #(.NCH(NCH), .CW(CW), .AW(AW), .SBW(SBW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .fg_i        (fg_i),
        .bg_i        (bg_i),
        .alpha_i     (alpha_i),
        .sb_i        (sb_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .color_o     (color_o),
        .sb_o        (sb_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cycle);
        end
    endtask

    // Blend computed straight from the arithmetic definition, one channel at a time.
    function automatic logic [DW-1:0] ref_blend(input logic [DW-1:0] fg, input logic [DW-1:0] bg,
                                                input logic [AW-1:0] a);
        int w, p;
        logic [DW-1:0] r;
        w = (int'(a) == 7) ? 8 : int'(a);
        r = '0;
        for (int c = 0; c < NCH; c++) begin
            p = int'(fg[c*CW +: CW]) * w + int'(bg[c*CW +: CW]) * (8 - w);
`ifdef BLEND_ROUND_EN
            p = p + 4;
`endif
            r[c*CW +: CW] = 4'(p / 8);
        end
        return r;
    endfunction

    always @(negedge clk_i) begin
        if (rst_i) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            exp_t e;
            check("in_ready", 32'(in_ready_o), 32'(!(out_valid_o && !out_ready_i)));
            if (stall_prev) begin
                check("stall_valid", 32'(out_valid_o), 32'd1);
                check("stall_color", 32'(color_o), 32'(prev_color));
                check("stall_sb", 32'(sb_o), 32'(prev_sb));
            end
            if (out_valid_o && out_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(out_valid_o), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("color", 32'(color_o), 32'(e.color));
                    check("sb", 32'(sb_o), 32'(e.sb));
                    if (lat_chk) check("latency", 32'(cycle - e.cyc), 32'd3);
                    last_color = color_o;
                    n_emit++;
                end
            end
            if (in_valid_i && in_ready_o) begin
                e.color = ref_blend(fg_i, bg_i, alpha_i);
                e.sb    = sb_i;
                e.cyc   = cycle;
                exp_q.push_back(e);
                n_acc++;
            end
            stall_prev = out_valid_o && !out_ready_i;
            prev_color = color_o;
            prev_sb    = sb_o;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic randomize_inputs();
        fg_i    = DW'($urandom);
        bg_i    = DW'($urandom);
        alpha_i = AW'($urandom_range(0, 7));
        sb_i    = SBW'($urandom);
    endtask

    task automatic send(input logic [DW-1:0] fg, input logic [DW-1:0] bg,
                        input logic [AW-1:0] a, input logic [SBW-1:0] sb);
        fg_i = fg; bg_i = bg; alpha_i = a; sb_i = sb;
        in_valid_i = 1'b1;
        step();
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
        step();
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int acc0;
        repeat (3) step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_color", 32'(color_o), 32'd0);
        check("rst_sb", 32'(sb_o), 32'd0);
        check("rst_ready", 32'(in_ready_o), 32'd1);
        step();

        // Directed boundary values.
        lat_chk = 1'b1;
        out_ready_i = 1'b1;
        send(12'hfff, 12'h000, 3'd3, 3'd5);
        wait_drain("drain_d1");
        check("fg15_a3", 32'(last_color), 32'(EXP_FG15_A3));
        send(12'h000, 12'hfff, 3'd3, 3'd2);
        wait_drain("drain_d2");
        check("bg15_a3", 32'(last_color), 32'h999);
        send(12'h5c1, 12'h3a7, 3'd0, 3'd1);
        wait_drain("drain_d3");
        check("alpha0_bg", 32'(last_color), 32'h3a7);
        send(12'haaa, 12'h222, 3'd7, 3'd6);
        wait_drain("drain_d4");
        check("alpha7_fg", 32'(last_color), 32'haaa);

        // Back-to-back stream at full throughput.
        in_valid_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            randomize_inputs();
            step();
        end
        in_valid_i = 1'b0;
        wait_drain("drain_stream");

        // Random valid and backpressure.
        lat_chk = 1'b0;
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            in_valid_i  = 1'($urandom);
            out_ready_i = 1'($urandom);
            step();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        wait_drain("drain_random");
        check("no_loss", 32'(n_emit), 32'(n_acc));

        // Fill, stall 10 cycles, release.
        acc0 = n_acc;
        out_ready_i = 1'b0;
        in_valid_i  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            randomize_inputs();
            step();
        end
        in_valid_i = 1'b0;
        repeat (10) step();
        check("fill_count", 32'(n_acc - acc0), 32'd3);
        out_ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i);
            check("drain_consec", 32'(out_valid_o), 32'd1);
            step();
        end
        @(negedge clk_i);
        check("drain_done", 32'(out_valid_o), 32'd0);
        step();

        // Reset with three beats in flight.
        lat_chk = 1'b1;
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            randomize_inputs();
            step();
        end
        in_valid_i = 1'b0;
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        @(negedge clk_i);
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_color", 32'(color_o), 32'd0);
        check("mid_rst_sb", 32'(sb_o), 32'd0);
        check("mid_rst_ready", 32'(in_ready_o), 32'd1);
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge clk_i);
            check("no_stale", 32'(out_valid_o), 32'd0);
        end
        step();
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle=%0d", cycle);
        $fatal(1, "watchdog expired");
    end

endmodule
